// File: rtl/seq_addsub_if.sv
// Operand/result handshake bundle for seq_addsub.
// master drives operands and accepts results; slave is the adder/subtractor.
interface seq_addsub_if #(
  parameter int WIDTH = 32
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             cary;
  logic             of;
  logic             eq;
  logic             zero;
  logic             neg;

  modport master (
    output in_valid, a, b, sub, out_ready,
    input  in_ready, out_valid, s, cary, of, eq, zero, neg
  );

  modport slave (
    input  in_valid, a, b, sub, out_ready,
    output in_ready, out_valid, s, cary, of, eq, zero, neg
  );
endinterface

// File: rtl/seq_addsub.sv
// Multi-cycle adder/subtractor: CHUNK bits per cycle with a registered carry.
// WIDTH must be a multiple of CHUNK; N = WIDTH/CHUNK RUN cycles per operation.
//
// state | meaning
// IDLE  | waiting for an operand beat, in_ready high
// RUN   | adding one chunk per cycle, LSB chunk first
// DONE  | result and flags presented, waiting for out_ready
module seq_addsub #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input logic         clk,
  input logic         rst,
  seq_addsub_if.slave bus
);
  localparam int N  = WIDTH / CHUNK;
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q, state_d;
  logic [KW-1:0]    k_q, k_d;
  logic             carry_q, carry_d;
  // a_q/b_q shift right one chunk per RUN cycle, so the live chunk is always at the bottom
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  // partial sum accumulates from the top; after N shifts it holds the full result
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             eq_pend_q, eq_pend_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             cary_q, cary_d;
  logic             of_q, of_d;
  logic             eq_q, eq_d;
  logic             zero_q, zero_d;
  logic             neg_q, neg_d;

  logic [CHUNK:0]   csum;
  logic [WIDTH-1:0] acc_next;

  // Next-state and datapath for the chunk-serial add
  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    carry_d   = carry_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    eq_pend_d = eq_pend_q;
    s_d       = s_q;
    cary_d    = cary_q;
    of_d      = of_q;
    eq_d      = eq_q;
    zero_d    = zero_q;
    neg_d     = neg_q;

    csum     = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]} + {{CHUNK{1'b0}}, carry_q};
    acc_next = WIDTH'({csum[CHUNK-1:0], acc_q} >> CHUNK);

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d       = bus.a;
          b_d       = bus.sub ? ~bus.b : bus.b;
          eq_pend_d = (bus.a == bus.b);
          carry_d   = bus.sub;
          k_d       = '0;
          state_d   = RUN;
        end
      end
      RUN: begin
        a_d     = a_q >> CHUNK;
        b_d     = b_q >> CHUNK;
        acc_d   = acc_next;
        carry_d = csum[CHUNK];
        k_d     = k_q + 1'b1;
        if (k_q == K_LAST) begin
          // the bottom of a_q/b_q now holds the operand MSB chunk
          s_d     = acc_next;
          cary_d  = csum[CHUNK];
          of_d    = (a_q[CHUNK-1] == b_q[CHUNK-1]) && (acc_next[WIDTH-1] != a_q[CHUNK-1]);
          eq_d    = eq_pend_q;
          zero_d  = (acc_next == '0);
          neg_d   = acc_next[WIDTH-1];
          k_d     = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      k_q       <= '0;
      carry_q   <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      eq_pend_q <= 1'b0;
      s_q       <= '0;
      cary_q    <= 1'b0;
      of_q      <= 1'b0;
      eq_q      <= 1'b0;
      zero_q    <= 1'b0;
      neg_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      carry_q   <= carry_d;
      a_q       <= a_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      eq_pend_q <= eq_pend_d;
      s_q       <= s_d;
      cary_q    <= cary_d;
      of_q      <= of_d;
      eq_q      <= eq_d;
      zero_q    <= zero_d;
      neg_q     <= neg_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE) && !rst;
  assign bus.out_valid = (state_q == DONE);
  assign bus.s         = s_q;
  assign bus.cary      = cary_q;
  assign bus.of        = of_q;
  assign bus.eq        = eq_q;
  assign bus.zero      = zero_q;
  assign bus.neg       = neg_q;
endmodule

// File: tb/tb_seq_addsub.sv
// Scoreboard bench for seq_addsub: 32/8 directed + random, 12/4 and 8/8 random.
module tb_seq_addsub;
  typedef struct {
    logic [63:0] s;
    logic        cary, of, eq, zero, neg;
    int          acc;
  } exp_t;

  logic clk;
  logic rst;
  logic rst2;
  int   cyc;
  int   ntests;
  int   nfail;

  exp_t        sbq[3][$];
  bit          seen[3];
  int          first[3];
  logic [69:0] snap[3];
  logic [69:0] last[3];
  int          xfer[3];
  int          width_of[3];
  int          nchunk[3];

  logic man_rdy32, bp32_rand, rnd_rdy32, rnd_rdy12, rnd_rdy8;
  bit   done12, done8;
  int   issued32;

  seq_addsub_if #(.WIDTH(32)) if32 ();
  seq_addsub_if #(.WIDTH(12)) if12 ();
  seq_addsub_if #(.WIDTH(8))  if8 ();

  seq_addsub #(.WIDTH(32), .CHUNK(8)) dut32 (.clk(clk), .rst(rst),  .bus(if32));
  seq_addsub #(.WIDTH(12), .CHUNK(4)) dut12 (.clk(clk), .rst(rst2), .bus(if12));
  seq_addsub #(.WIDTH(8),  .CHUNK(8)) dut8  (.clk(clk), .rst(rst2), .bus(if8));

  assign if32.out_ready = bp32_rand ? rnd_rdy32 : man_rdy32;
  assign if12.out_ready = rnd_rdy12;
  assign if8.out_ready  = rnd_rdy8;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: plain integer arithmetic on w-bit two's complement values
  function automatic exp_t model(input int w, input logic [63:0] a_in, input logic [63:0] b_in,
                                 input logic sb);
    exp_t m;
    longint unsigned mask, au, bu, u;
    longint sa, sbv, r, lim;
    mask = (64'd1 << w) - 64'd1;
    au   = a_in & mask;
    bu   = b_in & mask;
    sa   = au[w-1] ? longint'(au | ~mask) : longint'(au);
    sbv  = bu[w-1] ? longint'(bu | ~mask) : longint'(bu);
    u    = sb ? ((au - bu) & mask) : ((au + bu) & mask);
    r    = sb ? (sa - sbv) : (sa + sbv);
    lim  = longint'(64'd1 << (w - 1));
    m.s    = u;
    m.cary = sb ? (au >= bu) : (((au + bu) >> w) != 0);
    m.of   = (r >= lim) || (r < -lim);
    m.eq   = (au == bu);
    m.zero = (u == 0);
    m.neg  = u[w-1];
    m.acc  = 0;
    return m;
  endfunction

  function automatic logic [69:0] pk(input logic [63:0] s, input logic c, input logic o,
                                     input logic q, input logic z, input logic n);
    return {s, c, o, q, z, n};
  endfunction

  // Operand generator biased toward the sign/overflow boundaries
  function automatic logic [63:0] rv(input int w);
    logic [63:0] mask;
    logic [63:0] v;
    mask = (64'd1 << w) - 64'd1;
    case ($urandom_range(0, 7))
      0:       v = 64'd0;
      1:       v = mask;
      2:       v = 64'd1 << (w - 1);
      3:       v = (64'd1 << (w - 1)) - 64'd1;
      4:       v = 64'd1;
      default: v = {$urandom, $urandom};
    endcase
    return v & mask;
  endfunction

  task automatic chk(input string nm, input logic [69:0] got, input logic [69:0] exp);
    ntests++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s got=%h expected=%h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  task automatic mon(input int id, input logic r, input logic iv, input logic ir,
                     input logic [63:0] a, input logic [63:0] b, input logic sb,
                     input logic ov, input logic ordy, input logic [63:0] s, input logic c,
                     input logic o, input logic q, input logic z, input logic n);
    exp_t        e;
    logic [69:0] cur;
    cur = pk(s, c, o, q, z, n);
    if (r) begin
      sbq[id].delete();
      seen[id] = 0;
      return;
    end
    if (iv && ir) begin
      e     = model(width_of[id], a, b, sb);
      e.acc = cyc;
      sbq[id].push_back(e);
    end
    if (ov) begin
      if (!seen[id]) begin
        seen[id]  = 1;
        first[id] = cyc;
        snap[id]  = cur;
      end
      chk($sformatf("w%0d_in_ready_while_valid", width_of[id]), 70'(ir), 70'd0);
      if (ordy) begin
        if (sbq[id].size() == 0) begin
          chk($sformatf("w%0d_unexpected_result", width_of[id]), 70'(ov), 70'd0);
        end else begin
          e = sbq[id].pop_front();
          chk($sformatf("w%0d_result", width_of[id]), cur,
              pk(e.s, e.cary, e.of, e.eq, e.zero, e.neg));
          chk($sformatf("w%0d_latency", width_of[id]), 70'(first[id] - e.acc - 1),
              70'(nchunk[id]));
          chk($sformatf("w%0d_hold", width_of[id]), cur, snap[id]);
        end
        last[id] = cur;
        xfer[id]++;
        seen[id] = 0;
      end
    end
  endtask

  // Monitor: sample all three DUTs mid-cycle
  always @(negedge clk) begin
    mon(0, rst, if32.in_valid, if32.in_ready, 64'(if32.a), 64'(if32.b), if32.sub,
        if32.out_valid, if32.out_ready, 64'(if32.s), if32.cary, if32.of, if32.eq,
        if32.zero, if32.neg);
    mon(1, rst2, if12.in_valid, if12.in_ready, 64'(if12.a), 64'(if12.b), if12.sub,
        if12.out_valid, if12.out_ready, 64'(if12.s), if12.cary, if12.of, if12.eq,
        if12.zero, if12.neg);
    mon(2, rst2, if8.in_valid, if8.in_ready, 64'(if8.a), 64'(if8.b), if8.sub,
        if8.out_valid, if8.out_ready, 64'(if8.s), if8.cary, if8.of, if8.eq,
        if8.zero, if8.neg);
  end

  // Random downstream backpressure
  initial begin
    rnd_rdy32 = 1'b1;
    rnd_rdy12 = 1'b1;
    rnd_rdy8  = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      rnd_rdy32 = ($urandom_range(0, 3) != 0);
      rnd_rdy12 = ($urandom_range(0, 3) != 0);
      rnd_rdy8  = ($urandom_range(0, 2) != 0);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // Issue one operation on the 32-bit DUT; optionally wait for its result
  task automatic op32(input logic [31:0] a, input logic [31:0] b, input logic sb,
                      input bit wait_done);
    int to;
    int x0;
    x0 = xfer[0];
    @(posedge clk);
    #1;
    if32.a        = a;
    if32.b        = b;
    if32.sub      = sb;
    if32.in_valid = 1'b1;
    to = 0;
    @(negedge clk);
    while (!if32.in_ready && to < 100) begin
      @(negedge clk);
      to++;
    end
    if (!if32.in_ready) chk("w32_accept_timeout", 70'(if32.in_ready), 70'd1);
    else issued32++;
    @(posedge clk);
    #1;
    if32.in_valid = 1'b0;
    if32.a        = $urandom;
    if32.b        = $urandom;
    if32.sub      = ~sb;
    if (wait_done) begin
      to = 0;
      while (xfer[0] == x0 && to < 200) begin
        @(negedge clk);
        to++;
      end
      chk("w32_result_timeout", 70'(xfer[0] != x0), 70'd1);
    end
  endtask

  // 12/4 random driver
  initial begin : drv12
    int to;
    done12        = 0;
    if12.in_valid = 1'b0;
    if12.a        = '0;
    if12.b        = '0;
    if12.sub      = 1'b0;
    wait (!rst2);
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk);
      #1;
      if12.a        = 12'(rv(12));
      if12.b        = 12'(rv(12));
      if12.sub      = 1'($urandom_range(0, 1));
      if12.in_valid = 1'b1;
      to = 0;
      @(negedge clk);
      while (!if12.in_ready && to < 100) begin
        @(negedge clk);
        to++;
      end
      if (!if12.in_ready) chk("w12_accept_timeout", 70'(if12.in_ready), 70'd1);
      @(posedge clk);
      #1;
      if12.in_valid = 1'b0;
      if12.a        = 12'($urandom);
      if12.sub      = ~if12.sub;
    end
    done12 = 1;
  end

  // 8/8 random driver
  initial begin : drv8
    int to;
    done8        = 0;
    if8.in_valid = 1'b0;
    if8.a        = '0;
    if8.b        = '0;
    if8.sub      = 1'b0;
    wait (!rst2);
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk);
      #1;
      if8.a        = 8'(rv(8));
      if8.b        = 8'(rv(8));
      if8.sub      = 1'($urandom_range(0, 1));
      if8.in_valid = 1'b1;
      to = 0;
      @(negedge clk);
      while (!if8.in_ready && to < 100) begin
        @(negedge clk);
        to++;
      end
      if (!if8.in_ready) chk("w8_accept_timeout", 70'(if8.in_ready), 70'd1);
      @(posedge clk);
      #1;
      if8.in_valid = 1'b0;
      if8.b        = 8'($urandom);
      if8.sub      = ~if8.sub;
    end
    done8 = 1;
  end

  // Main sequence: reset, directed cases, backpressure, abort, random
  initial begin : main
    int  to;
    bit  ov_seen;
    ntests   = 0;
    nfail    = 0;
    issued32 = 0;
    width_of = '{32, 12, 8};
    nchunk   = '{4, 3, 1};
    xfer     = '{0, 0, 0};
    seen     = '{0, 0, 0};
    rst       = 1'b1;
    rst2      = 1'b1;
    man_rdy32 = 1'b1;
    bp32_rand = 1'b0;
    if32.in_valid = 1'b0;
    if32.a        = '0;
    if32.b        = '0;
    if32.sub      = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 70'(if32.in_ready), 70'd0);
    chk("rst_out_valid", 70'(if32.out_valid), 70'd0);
    chk("rst_outputs", pk(64'(if32.s), if32.cary, if32.of, if32.eq, if32.zero, if32.neg),
        70'd0);
    @(posedge clk);
    #1;
    rst  = 1'b0;
    rst2 = 1'b0;
    @(negedge clk);
    chk("in_ready_after_rst", 70'(if32.in_ready), 70'd1);

    op32(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1);
    chk("ffffffff_plus_1", last[0], pk(64'h0, 1, 0, 0, 1, 0));
    op32(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1);
    chk("maxpos_plus_1", last[0], pk(64'h8000_0000, 0, 1, 0, 0, 1));
    op32(32'h8000_0000, 32'h0000_0001, 1'b1, 1);
    chk("minneg_minus_1", last[0], pk(64'h7FFF_FFFF, 1, 1, 0, 0, 0));
    op32(32'h1234_5678, 32'h1234_5678, 1'b1, 1);
    chk("equal_sub", last[0], pk(64'h0, 1, 0, 1, 1, 0));
    op32(32'd5, 32'd7, 1'b1, 1);
    chk("5_minus_7", last[0], pk(64'hFFFF_FFFE, 0, 0, 0, 0, 1));

    // Backpressure: hold the result for 10 cycles
    man_rdy32 = 1'b0;
    op32(32'd100, 32'd23, 1'b0, 0);
    to = 0;
    while (!if32.out_valid && to < 20) begin
      @(negedge clk);
      to++;
    end
    repeat (10) @(negedge clk);
    chk("bp_valid_held", 70'(if32.out_valid), 70'd1);
    chk("bp_outputs", pk(64'(if32.s), if32.cary, if32.of, if32.eq, if32.zero, if32.neg),
        pk(64'd123, 0, 0, 0, 0, 0));
    @(posedge clk);
    #1;
    man_rdy32 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("in_ready_after_xfer", 70'(if32.in_ready), 70'd1);
    chk("valid_drop_after_xfer", 70'(if32.out_valid), 70'd0);
    chk("bp_result", last[0], pk(64'd123, 0, 0, 0, 0, 0));
    op32(32'h0000_0010, 32'h0000_0020, 1'b1, 1);
    chk("b2b_sub", last[0], pk(64'hFFFF_FFF0, 0, 0, 0, 0, 1));
    op32(32'h4000_0000, 32'h4000_0000, 1'b0, 1);
    chk("b2b_add", last[0], pk(64'h8000_0000, 0, 1, 1, 0, 1));

    // Abort with reset once k has reached 2
    @(posedge clk);
    #1;
    if32.a        = 32'h1111_1111;
    if32.b        = 32'h2222_2222;
    if32.sub      = 1'b0;
    if32.in_valid = 1'b1;
    @(negedge clk);
    chk("abort_accept", 70'(if32.in_ready), 70'd1);
    @(posedge clk);
    #1;
    if32.in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("in_ready_after_abort", 70'(if32.in_ready), 70'd1);
    ov_seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (if32.out_valid) ov_seen = 1;
    end
    chk("abort_no_valid", 70'(ov_seen), 70'd0);
    op32(32'd3, 32'd4, 1'b0, 1);
    chk("3_plus_4", last[0], pk(64'd7, 0, 0, 0, 0, 0));

    // Random 32-bit traffic under random backpressure
    bp32_rand = 1'b1;
    for (int i = 0; i < 300; i++) begin
      op32(32'(rv(32)), 32'(rv(32)), 1'($urandom_range(0, 1)), 0);
    end

    to = 0;
    while ((sbq[0].size() != 0 || sbq[1].size() != 0 || sbq[2].size() != 0 ||
            !done12 || !done8) && to < 20000) begin
      @(negedge clk);
      to++;
    end
    repeat (10) @(negedge clk);
    chk("w32_transfer_count", 70'(xfer[0]), 70'(issued32));
    chk("w12_transfer_count", 70'(xfer[1]), 70'd1000);
    chk("w8_transfer_count", 70'(xfer[2]), 70'd1000);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule

// File: doc/seq_addsub.md
# seq_addsub

Multi-cycle, parametrised adder/subtractor. It is the successor to the ALU's single-cycle 32-bit combinational adder. Operands are accepted over a valid/ready handshake and added or subtracted CHUNK bits per clock, with the carry rippling through a registered carry flop. The block returns sum, carry, signed overflow, equality, zero and negative flags over a second valid/ready handshake. It sits between the ALU operand registers and the result/flag writeback, and trades latency for a short carry chain at large WIDTH.

## Interface
- WIDTH, 32: operand and result width in bits. Must satisfy WIDTH ≥ 2.
- CHUNK, 8: bits processed per RUN cycle. WIDTH must be an integer multiple of CHUNK, and CHUNK ≥ 1. N = WIDTH/CHUNK.
- clk  in  1  sole clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand beat offered.
- in_ready  out  1  block can accept an operand beat; high only in IDLE and when rst is low.
- a  in  WIDTH  operand A, two's complement.
- b  in  WIDTH  operand B, two's complement.
- sub  in  1  0: s = a + b; 1: s = a − b.
- out_valid  out  1  result and flags valid; held until taken.
- out_ready  in  1  downstream accepts the result.
- s  out  WIDTH  result, modulo 2^WIDTH.
- cary  out  1  carry out of bit WIDTH−1 (for subtract: 1 = no borrow).
- of  out  1  signed overflow or underflow.
- eq  out  1  a == b, independent of sub.
- zero  out  1  s == 0.
- neg  out  1  s[WIDTH−1].

## Operation
- FSM states:
  - IDLE: in_ready=1. On in_valid: latch a, b_eff = sub ? ~b : b, and eq = (a==b). Set carry flop = sub, chunk index k=0, go to RUN.
  - RUN: each cycle computes {c, s[k*CHUNK +: CHUNK]} = a_chunk + b_eff_chunk + carry, stores c in the carry flop, and increments k. When k==N−1, also register the final flags and go to DONE.
  - DONE: out_valid=1. On out_ready, go to IDLE.
- Width rules:
  - cary = carry out of the final chunk.
  - of = carry into bit WIDTH−1 XOR carry out of bit WIDTH−1. Equivalently, of = (a[MSB]==b_eff[MSB]) && (s[MSB]!=a[MSB]).
  - zero and neg are derived from the complete s.
- Operands are captured at acceptance. Changes on a, b or sub after acceptance have no effect.
- s, cary, of, eq, zero and neg are registered. They hold their values from DONE until the next operation's DONE; they are not cleared on return to IDLE.
- s bits of chunks not yet computed are undefined while in RUN. Only values qualified by out_valid are contractual.

## Timing
- Reset (rst high at a rising edge): state=IDLE, k=0, carry flop=0, out_valid=0, s=0, and cary=of=eq=zero=neg=0. in_ready=0 while rst is high and 1 in the first cycle after release.
- rst mid-RUN or mid-DONE aborts the operation. No out_valid is produced for it.
- Latency: acceptance at edge E0, chunk j computed at edge E(j+1), out_valid high after edge EN. N=4 for the defaults.
- out_valid and all outputs stay stable while out_valid=1 and out_ready=0 (backpressure of any length).
- Transfer at edge E(N+1) if out_ready is already high. in_ready rises the cycle after transfer; no in/out overlap.
- Maximum throughput: one operation per N+2 cycles.
- in_valid while in_ready=0 is ignored. The source must hold the beat until it is accepted.
- N=1 (CHUNK==WIDTH) is legal: IDLE→RUN→DONE with a single RUN cycle.

## Test plan
- Defaults: a=0xFFFFFFFF, b=0x00000001, sub=0. out_valid appears 4 cycles after acceptance with s=0, cary=1, of=0, zero=1, eq=0, neg=0.
- a=0x7FFFFFFF, b=1, add → s=0x80000000, of=1, neg=1, cary=0. Then a=0x80000000, b=1, sub → s=0x7FFFFFFF, of=1, cary=1.
- a=b=0x12345678, sub=1 → s=0, zero=1, eq=1, cary=1, of=0. a=5, b=7, sub=1 → s=0xFFFFFFFE, cary=0, neg=1.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid; outputs stay stable and in_ready stays 0. Then pulse out_ready; in_ready rises the next cycle and back-to-back ops complete with correct results.
- Assert rst during RUN with k=2: out_valid never rises for that op. in_ready=1 after release, and a new op 3+4 returns s=7.
- WIDTH=12, CHUNK=4 and WIDTH=8, CHUNK=8: randomized 1000 ops compared to a {a[MSB],a}+{b[MSB],b} reference model, with latency checked equal to N.
